// File: rtl/game_event_fifo.sv
// Hit-event FIFO with frame timestamps and player scores for the tank game.
// Avalon-MM slave: STATUS, DATA (pop), SCORES, CONTROL; irq while events are queued.
module game_event_fifo #(
    parameter int DEPTH   = 16,
    parameter int FRAME_W = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        vsync,
    input  logic        player_1_hit,
    input  logic        player_2_hit,
    input  logic        avs_chipselect,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // [0],[1] synchroniser stages, [2] previous value for edge detect
    logic [2:0] vs_sh, p1_sh, p2_sh;
    logic vs_rise, p1_rise, p2_rise, hit_any;

    logic [17:0]        mem [DEPTH];
    logic [AW-1:0]      wp, rp;
    logic [CW-1:0]      count, count_next;
    logic               overflow;
    logic [FRAME_W-1:0] frame;
    logic [7:0]         p1_score, p2_score;

    logic rd, ctrl_wr, clr_scores, clr_ovf, flush;
    logic empty, full, pop, push_req, push, ovf_set;
    logic unused_wdata;

    assign vs_rise = vs_sh[1] & ~vs_sh[2];
    assign p1_rise = p1_sh[1] & ~p1_sh[2];
    assign p2_rise = p2_sh[1] & ~p2_sh[2];
    assign hit_any = p1_rise | p2_rise;

    assign rd         = avs_chipselect & avs_read;
    assign ctrl_wr    = avs_chipselect & avs_write & (avs_address == 2'd3);
    assign clr_scores = ctrl_wr & avs_writedata[0];
    assign clr_ovf    = ctrl_wr & avs_writedata[1];
    assign flush      = ctrl_wr & avs_writedata[2];
    assign unused_wdata = ^avs_writedata[31:3];

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = rd & (avs_address == 2'd1) & ~empty;
    assign push_req = hit_any & ~flush;
    // a same-cycle pop frees the slot, so a full FIFO still accepts
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_sh <= '0;
            p1_sh <= '0;
            p2_sh <= '0;
        end else begin
            vs_sh <= {vs_sh[1:0], vsync};
            p1_sh <= {p1_sh[1:0], player_1_hit};
            p2_sh <= {p2_sh[1:0], player_2_hit};
        end
    end

    always_ff @(posedge Clk) begin
        if (push)
            mem[wp] <= {p2_rise, p1_rise, 16'(frame)};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            overflow <= 1'b0;
            frame    <= '0;
            irq      <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            if (vs_rise)
                frame <= frame + FRAME_W'(1);
            irq <= ~empty;
        end
    end

    // P1 being hit scores for P2 and vice versa; clear beats a same-cycle hit
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            p1_score <= '0;
            p2_score <= '0;
        end else if (clr_scores) begin
            p1_score <= '0;
            p2_score <= '0;
        end else begin
            if (p2_rise && p1_score != 8'hFF)
                p1_score <= p1_score + 8'd1;
            if (p1_rise && p2_score != 8'hFF)
                p2_score <= p2_score + 8'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            avs_readdata <= '0;
        end else if (rd) begin
            unique case (avs_address)
                2'd0: avs_readdata <= {21'd0, overflow, full, empty, 8'(count)};
                2'd1: avs_readdata <= empty ? 32'd0 : {14'd0, mem[rp]};
                2'd2: avs_readdata <= {16'd0, p2_score, p1_score};
                2'd3: avs_readdata <= 32'd0;
            endcase
        end
    end
endmodule

// File: doc/game_event_fifo.md
Name: game_event_fifo

Overview:
- Hardware-to-software return path for the tank game, in the opposite direction to the keycode PIOs that the NIOS II writes into fabric.
- Captures player-hit events from the hit detector, timestamps each with a frame number, and buffers them in a FIFO.
- Keeps per-player scores.
- Exposes FIFO, scores and control as an Avalon-MM slave, so the NIOS can read game events and drive the HEX/LED score display.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..64.
- FRAME_W, 16, frame counter width; 1..16.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high reset.
- vsync  in  1  VGA vertical sync level, asynchronous to Clk.
- player_1_hit  in  1  hit level from hit detector, asynchronous to Clk.
- player_2_hit  in  1  hit level from hit detector, asynchronous to Clk.
- avs_chipselect  in  1  slave select.
- avs_address  in  2  word register address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- irq  out  1  level interrupt: FIFO non-empty.

Behaviour:

Reset:
- Reset asynchronous and active-high; clock Clk. Applies async at any time, including mid-access.
- On reset: FIFO empty (count 0), pointers 0, overflow 0, frame counter 0, both scores 0, synchroniser flops 0, avs_readdata 0, irq 0.

Input capture:
- Each of vsync, player_1_hit, player_2_hit passes through a 2-flop synchroniser, then a registered rising-edge detect.
- An input rise is acted on at the 3rd Clk edge after it meets setup.

Frame counter:
- Increments on each detected vsync rising edge.
- Wraps 2^FRAME_W-1 -> 0.

Event push:
- On a detected hit edge, push one word:
  - [31:18] = 0
  - [17:16] type: 01 = P1 hit, 10 = P2 hit, 11 = both edges detected in the same cycle
  - [15:0] = frame counter value before any same-cycle increment, zero-extended.
- Both edges in the same cycle produce exactly one entry.

Scores:
- A P1 hit increments p2_score; a P2 hit increments p1_score. Type 11 increments both.
- 8-bit, saturating at 255.
- Scores update even when the push is dropped.

Register map (word addresses; a read or write takes effect only with avs_chipselect):
- 0 STATUS (read):
  - [7:0] count
  - [8] empty
  - [9] full
  - [10] overflow (sticky).
- 1 DATA (read): returns the head entry and pops it.
  - If empty, returns 0 and changes no state.
- 2 SCORES (read): [7:0] p1_score, [15:8] p2_score.
- 3 CONTROL (write), bits self-clearing:
  - [0] clear scores
  - [1] clear overflow
  - [2] flush FIFO (count 0, pointers equal).
- Reads of address 3 and writes to 0-2 return 0 / are ignored.

Read timing:
- Read latency 1 cycle: avs_readdata is valid on the Clk edge after the cycle in which avs_read is sampled.
- Otherwise avs_readdata holds its last value.
- Pop takes effect on the same edge.
- STATUS read in the same cycle as a push/pop returns pre-update values.

FIFO boundaries:
- Push when full with no same-cycle pop: entry dropped, overflow set to 1.
- Push and pop in the same cycle: both occur, count unchanged. This applies when full (no overflow) and when count is 1.
- Pop with push on an empty FIFO: pop returns 0, push is accepted, count becomes 1.
- Flush with same-cycle push: the flush wins and the new event is discarded.
- Clear overflow with a same-cycle overflowing push: overflow ends up 1.
- Clear scores with a same-cycle hit: scores end up 0.

irq:
- Registered; equals !empty one cycle after any count change.

Test Plan:
1. Reset, 3 vsync pulses, 1 player_1_hit pulse. Expect STATUS = 0x001 (count 1, not empty). DATA = 0x0001_0003. SCORES = 0x0100. Subsequent STATUS = 0x100 (empty). irq 1 then 0.
2. player_1_hit and player_2_hit rise together at frame 5. Expect a single entry 0x0003_0005 and SCORES = 0x0101.
3. 17 P2 hits with DEPTH = 16, no reads. Expect STATUS count 16, full = 1, overflow = 1, p1_score = 17. Then 16 DATA reads return ascending frames; the 17th DATA read returns 0. CONTROL write 0x2 clears overflow.
4. FIFO full; a DATA read coincides with the pushing edge. Expect count stays 16, overflow stays 0, and the new entry appears as the last of the 16 reads.
5. 300 P2 hits. Expect p1_score saturates at 0xFF. CONTROL write 0x1 gives SCORES = 0. CONTROL write 0x4 with 5 entries queued gives STATUS = 0x100.
6. Assert Reset mid-DATA-read with 4 entries queued. Expect avs_readdata = 0, count 0, irq 0 immediately (async). 65536 vsync pulses then a hit gives frame field 0x0000.
